// File: rtl/crank_cam_emulator.sv
// Crank/cam trigger-wheel generator: missing-tooth crank signal plus a
// half-speed cam window. The tooth period is programmed in clock cycles.
module crank_cam_emulator #(
  parameter int TEETH      = 60,
  parameter int MISSING    = 2,
  parameter int TOOTH_W    = 6,
  parameter int PERIOD_W   = 24,
  parameter int PERIOD_MIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [PERIOD_W-1:0] period,
  input  logic [TOOTH_W-1:0]  cam_start,
  input  logic [TOOTH_W-1:0]  cam_len,
  output logic                cap,
  output logic                cam,
  output logic [TOOTH_W-1:0]  tooth,
  output logic                rev,
  output logic                sync_pulse
);

  // The gap needs at least one real tooth before it and a slot 0 after it.
  if (TEETH <= MISSING + 1) begin : g_chk_teeth
    $error("crank_cam_emulator: TEETH must exceed MISSING+1");
  end
  if ((1 << TOOTH_W) < TEETH) begin : g_chk_width
    $error("crank_cam_emulator: TOOTH_W too narrow for TEETH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [TOOTH_W-1:0]  LAST_T  = TOOTH_W'(TEETH - 1);
  localparam logic [TOOTH_W-1:0]  REAL_T  = TOOTH_W'(TEETH - MISSING);
  localparam logic [TOOTH_W:0]    TEETH_X = (TOOTH_W + 1)'(TEETH);
  localparam logic [PERIOD_W-1:0] PMIN    = PERIOD_W'(PERIOD_MIN);

  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p < PMIN) ? PMIN : p;
  endfunction

  // Exclusive end of the cam window, widened so start+len cannot wrap.
  function automatic logic [TOOTH_W:0] cam_limit(input logic [TOOTH_W-1:0] s,
                                                 input logic [TOOTH_W-1:0] l);
    logic [TOOTH_W:0] e;
    e = {1'b0, s} + {1'b0, l};
    return (e > TEETH_X) ? TEETH_X : e;
  endfunction

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] ph_q, ph_d;
  logic [TOOTH_W-1:0]  tooth_cnt_q, tooth_cnt_d;
  logic                rev_cnt_q, rev_cnt_d;
  logic                load;

  // Slot configuration, refreshed only at slot start.
  logic [PERIOD_W-1:0] p_q, p_d;
  logic [TOOTH_W-1:0]  cs_q, cs_d;
  logic [TOOTH_W-1:0]  cl_q, cl_d;

  // Registered outputs.
  logic                cap_q, cap_d;
  logic                cam_q, cam_d;
  logic [TOOTH_W-1:0]  tooth_q, tooth_d;
  logic                rev_q, rev_d;
  logic                sync_q, sync_d;

  // Control registers: FSM state and phase/tooth/revolution counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      tooth_cnt_q <= '0;
      rev_cnt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      tooth_cnt_q <= tooth_cnt_d;
      rev_cnt_q   <= rev_cnt_d;
    end
  end

  // Next-state logic: start/stop and slot advance; load marks a slot start.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    tooth_cnt_d = tooth_cnt_q;
    rev_cnt_d   = rev_cnt_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        ph_d        = '0;
        tooth_cnt_d = '0;
        rev_cnt_d   = 1'b0;
        if (ena) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!ena) begin
          state_d     = IDLE;
          ph_d        = '0;
          tooth_cnt_d = '0;
          rev_cnt_d   = 1'b0;
        end else if (ph_q == p_q - PERIOD_W'(1)) begin
          ph_d = '0;
          load = 1'b1;
          if (tooth_cnt_q == LAST_T) begin
            tooth_cnt_d = '0;
            rev_cnt_d   = ~rev_cnt_q;
          end else begin
            tooth_cnt_d = tooth_cnt_q + TOOTH_W'(1);
          end
        end else begin
          ph_d = ph_q + PERIOD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample period and cam window at slot start so a slot is never resized.
  always_comb begin
    p_d  = p_q;
    cs_d = cs_q;
    cl_d = cl_q;
    if (load) begin
      p_d  = clamp_period(period);
      cs_d = cam_start;
      cl_d = cam_len;
    end
  end

  // Slot configuration is data; it is always loaded before it is used in RUN.
  always_ff @(posedge clk) begin
    p_q  <= p_d;
    cs_q <= cs_d;
    cl_q <= cl_d;
  end

  // Decode waveform outputs from the current counters.
  always_comb begin
    cap_d   = 1'b1;
    cam_d   = 1'b0;
    tooth_d = '0;
    rev_d   = 1'b0;
    sync_d  = 1'b0;
    if (state_q == RUN) begin
      tooth_d = tooth_cnt_q;
      rev_d   = rev_cnt_q;
      sync_d  = (tooth_cnt_q == '0) && (ph_q == '0);
      // Low for the first floor(P/2) cycles of a real tooth; missing slots stay high.
      cap_d   = (tooth_cnt_q >= REAL_T) || (ph_q >= (p_q >> 1));
      cam_d   = !rev_cnt_q && (tooth_cnt_q >= cs_q) &&
                ({1'b0, tooth_cnt_q} < cam_limit(cs_q, cl_q));
    end
  end

  // Output registers, forced to idle values by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q   <= 1'b1;
      cam_q   <= 1'b0;
      tooth_q <= '0;
      rev_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      cam_q   <= cam_d;
      tooth_q <= tooth_d;
      rev_q   <= rev_d;
      sync_q  <= sync_d;
    end
  end

  assign cap        = cap_q;
  assign cam        = cam_q;
  assign tooth      = tooth_q;
  assign rev        = rev_q;
  assign sync_pulse = sync_q;

endmodule

// File: tb/tb_crank_cam_emulator.sv
// Self-checking bench for crank_cam_emulator (TEETH=60, MISSING=2).
module tb_crank_cam_emulator;

  localparam int TEETH = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [23:0] period = 24'd8;
  logic [5:0]  cam_start = 6'd0;
  logic [5:0]  cam_len = 6'd0;
  logic        cap, cam, rev, sync_pulse;
  logic [5:0]  tooth;

  int total = 0;
  int bad   = 0;

  crank_cam_emulator dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .period     (period),
    .cam_start  (cam_start),
    .cam_len    (cam_len),
    .cap        (cap),
    .cam        (cam),
    .tooth      (tooth),
    .rev        (rev),
    .sync_pulse (sync_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int cs;
    int cl;
    int slot;   // expected slot length P
    int low;    // expected low cycles in a real slot
    int camc;   // expected cam-high cycles per 720 degrees
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge where sync_pulse is seen high.
  task automatic wait_sync(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      if (sync_pulse) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_tooth(input int t, input bit need_low, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      if (tooth == 6'(t) && (!need_low || cap == 1'b0)) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Observe one 720-degree cycle starting at the sync cycle.
  task automatic run_window(input int p, output int edges, output int mn, output int mx,
                            output int camc, output int syncs, output int low0,
                            output int rev0, output int rev1, output int sync_end);
    int last;
    bit prev;
    last = -1; prev = 1'b1;
    edges = 0; mn = 1 << 30; mx = 0; camc = 0; syncs = 0; low0 = 0; rev0 = -1; rev1 = -1;
    for (int i = 0; i < 2 * TEETH * p; i++) begin
      if (prev && !cap) begin
        edges++;
        if (last >= 0) begin
          if (i - last < mn) mn = i - last;
          if (i - last > mx) mx = i - last;
        end
        last = i;
      end
      prev = cap;
      if (cam) camc++;
      if (sync_pulse) syncs++;
      if (i < p && !cap) low0++;
      if (i == 0) rev0 = int'(rev);
      if (i == TEETH * p) rev1 = int'(rev);
      @(negedge clk);
    end
    sync_end = int'(sync_pulse);
  endtask

  initial begin
    bit ok;
    int edges, mn, mx, camc, syncs, low0, rev0, rev1, sync_end;
    int e1, e2, last, nedge;
    bit prev;

    vecs[0] = '{period: 8,  cs: 10, cl: 5,  slot: 8, low: 4, camc: 40};
    vecs[1] = '{period: 0,  cs: 55, cl: 20, slot: 4, low: 2, camc: 20};
    vecs[2] = '{period: 1,  cs: 0,  cl: 0,  slot: 4, low: 2, camc: 0};
    vecs[3] = '{period: 3,  cs: 60, cl: 5,  slot: 4, low: 2, camc: 0};
    vecs[4] = '{period: 9,  cs: 0,  cl: 63, slot: 9, low: 4, camc: 540};
    vecs[5] = '{period: 5,  cs: 58, cl: 2,  slot: 5, low: 2, camc: 10};
    vecs[6] = '{period: 6,  cs: 0,  cl: 1,  slot: 6, low: 3, camc: 6};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cap", cap, 1);
    check("rst_cam", cam, 0);
    check("rst_tooth", tooth, 0);
    check("rst_rev", rev, 0);
    check("rst_sync", sync_pulse, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cap", cap, 1);

    // Table-driven full 720-degree cycles
    for (int v = 0; v < 7; v++) begin
      do_reset();
      period    = 24'(vecs[v].period);
      cam_start = 6'(vecs[v].cs);
      cam_len   = 6'(vecs[v].cl);
      ena       = 1'b1;
      wait_sync(10, ok);
      check($sformatf("v%0d_sync_start", v), ok, 1);
      if (ok) begin
        run_window(vecs[v].slot, edges, mn, mx, camc, syncs, low0, rev0, rev1, sync_end);
        check($sformatf("v%0d_edges", v), edges, 2 * (TEETH - 2));
        check($sformatf("v%0d_min_gap", v), mn, vecs[v].slot);
        check($sformatf("v%0d_max_gap", v), mx, 3 * vecs[v].slot);
        check($sformatf("v%0d_cam", v), camc, vecs[v].camc);
        check($sformatf("v%0d_syncs", v), syncs, 2);
        check($sformatf("v%0d_low", v), low0, vecs[v].low);
        check($sformatf("v%0d_rev0", v), rev0, 0);
        check($sformatf("v%0d_rev1", v), rev1, 1);
        check($sformatf("v%0d_sync_end", v), sync_end, 1);
      end
      ena = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Mid-slot period change 8 -> 20: slot 0 stays 8, slot 1 becomes 20
    do_reset();
    period = 24'd8; cam_start = 6'd0; cam_len = 6'd0;
    ena = 1'b1;
    wait_sync(10, ok);
    check("mid_sync", ok, 1);
    e1 = -1; e2 = -1; last = 0; nedge = 0; prev = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) period = 24'd20;
      if (prev && !cap) begin
        if (nedge == 1) e1 = i;
        if (nedge == 2) e2 = i;
        nedge++;
      end
      prev = cap;
      @(negedge clk);
    end
    check("mid_first_slot", e1, 8);
    check("mid_second_slot", e2 - e1, 20);

    // Stop inside the gap, then restart
    do_reset();
    period = 24'd4;
    ena = 1'b1;
    wait_sync(10, ok);
    check("stop_sync", ok, 1);
    wait_tooth(58, 1'b0, 400, ok);
    check("stop_reach_gap", ok, 1);
    ena = 1'b0;
    @(negedge clk);
    check("stop_lat_tooth", tooth, 58);
    @(negedge clk);
    check("stop_tooth", tooth, 0);
    check("stop_cap", cap, 1);
    check("stop_sync_lo", sync_pulse, 0);
    ena = 1'b1;
    @(negedge clk);
    check("restart_lat", sync_pulse, 0);
    @(negedge clk);
    check("restart_sync", sync_pulse, 1);
    check("restart_cap", cap, 0);
    check("restart_tooth", tooth, 0);
    check("restart_rev", rev, 0);

    // Asynchronous reset mid-run
    do_reset();
    period = 24'd8; cam_start = 6'd0; cam_len = 6'd10;
    ena = 1'b1;
    wait_tooth(5, 1'b1, 200, ok);
    check("arst_reach", ok, 1);
    check("arst_pre_cam", cam, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_cap", cap, 1);
    check("arst_cam", cam, 0);
    check("arst_tooth", tooth, 0);
    check("arst_sync", sync_pulse, 0);
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle_tooth", tooth, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crank_cam_emulator.md
# crank_cam_emulator

Synthesizable crank/cam trigger-wheel generator that produces a missing-tooth crank signal and a half-speed cam signal from a programmable tooth period. It is the transmitting end of the angle-generator input path: its `cap`/`cam` outputs drive the angle generator's crank/cam inputs in loopback benches and on-board self-test. Tooth spacing is set in clock cycles so the generated intervals line up directly with the receiver's 24-bit period counters.

## Interface

Parameters:
- `TEETH`, 60: tooth slots per crank revolution, including the missing teeth.
- `MISSING`, 2: missing teeth at the end of each revolution.
- `TOOTH_W`, 6: width of tooth indices; must satisfy 2^TOOTH_W >= TEETH.
- `PERIOD_W`, 24: width of the tooth period.
- `PERIOD_MIN`, 4: smallest tooth period used; programmed values below this are clamped to it.

Ports (clock and reset first):
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ena` in 1: run enable. 1 = generate; 0 = go idle.
- `period` in PERIOD_W: clock cycles per tooth slot. Sampled only at slot start.
- `cam_start` in TOOTH_W: first tooth slot of the cam window.
- `cam_len` in TOOTH_W: cam window length in slots; 0 = cam never asserted.
- `cap` out 1: crank signal. The active edge is the falling edge.
- `cam` out 1: cam signal, active-high window.
- `tooth` out TOOTH_W: current slot index, 0..TEETH-1.
- `rev` out 1: revolution parity. 0 = first crank revolution of the 720° cycle.
- `sync_pulse` out 1: one-cycle pulse on the first cycle of slot 0.

## Operation

- States: IDLE, RUN.
- IDLE:
  - Outputs: `cap`=1, `cam`=0, `tooth`=0, `rev`=0, `sync_pulse`=0.
  - Internal phase counter `ph`=0.
- IDLE→RUN: `ena`=1 sampled. The next cycle is cycle 0 of slot 0 of revolution 0.
- RUN→IDLE: `ena`=0 sampled, at any point, including inside the gap. Takes effect next cycle and needs no slot completion.
- Slot timing:
  - At each slot start, latch `P` = max(`period`, `PERIOD_MIN`).
  - `ph` counts 0..P-1.
  - At `ph`=P-1, `ph` wraps to 0 and `tooth` increments.
  - At `tooth`=TEETH-1, `tooth` wraps to 0 and `rev` toggles.
- Crank signal:
  - Real tooth slots (`tooth` < TEETH-MISSING): `cap`=0 for `ph` < P>>1 and 1 otherwise. This gives one falling edge per real slot, P cycles apart.
  - Missing slots: `cap` held at 1, so there is no falling edge. The interval between the last real edge and the slot-0 edge is (MISSING+1)·P.
  - P>>1 is a floor. With odd P, the low phase is the shorter one.
- Cam signal:
  - `cam`=1 iff `rev`=0 and `cam_start` <= `tooth` < min(`cam_start`+`cam_len`, TEETH).
  - The sum is computed at TOOTH_W+1 bits, so there is no wrap-around.
  - `cam_start` >= TEETH means the window is empty.
  - `cam_start` and `cam_len` are sampled at slot start, together with `period`.
- `sync_pulse`: 1 exactly when `tooth`=0 and `ph`=0 in RUN.
- Parameter-time check: the implementation must require `TEETH` > `MISSING`+1.

## Timing

- All outputs are registered and change only on `clk` rising edges, or asynchronously on reset.
- Reset values: `cap`=1, `cam`=0, `tooth`=0, `rev`=0, `sync_pulse`=0; state IDLE. Reset overrides everything, mid-slot included.
- Start latency: `ena` sampled high at edge N.
  - From edge N+1: `cap`=0, `sync_pulse`=1, `tooth`=0.
- Period change: a new `period` written mid-slot has no effect until the next slot start; it never truncates or stretches the current slot.
- Slot-start boundaries: `ena` falling and a slot start on the same edge → IDLE wins. `period` changing on the same edge as a slot start → the new value is used.
- Slot length: every slot is exactly P cycles. A full revolution is TEETH·P cycles; a 720° cycle is 2·TEETH·P cycles.

## Test plan

- Basic spacing, TEETH=60, MISSING=2, `period`=8, `cam_start`=10, `cam_len`=5. Required:
  - `cap` falling edges 8 cycles apart.
  - One 24-cycle gap per revolution.
  - `sync_pulse` every 480 cycles.
  - `cam` high for 40 cycles starting at tooth 10 of every other revolution.
- Clamp: `period`=0, then 1, then 3 → every slot lasts 4 cycles, with `cap` low 2 and high 2. `period`=9 → low 4, high 5.
- Mid-slot change: `period` changes 8→20 at `ph`=3 → current slot completes in 8 cycles; the next slot is 20.
- Cam bounds:
  - `cam_start`=55, `cam_len`=20 → `cam` high for slots 55..59 only.
  - `cam_len`=0 → `cam` never asserted.
  - `cam_start`=60 → `cam` never asserted.
- Stop/restart: drop `ena` inside the gap → next cycle `cap`=1, `tooth`=0. Re-raise `ena` → slot 0 of `rev`=0 begins one cycle later with `sync_pulse`.
- Reset mid-run: assert `rst` asynchronously between edges → all outputs take their reset values immediately. Loopback into the angle generator with `period`=1000 → `hwag_start` asserts after the first detected gap.
